aeses_ctrl: RTL
===============

Name: aeses_ctrl

Overview:
Parametrised successor controller for the AES engine. It supports runtime-selectable AES-128/192/256, stores round keys in an indexed key store rather than a shift register, and accepts and delivers blocks with valid/ready handshakes. It also provides a one-entry output holding register. It sits between the key scheduler, the round-iterative cipher core and the system bus.

Parameters:
BLK_W, 128, block and round-key width in bits
MAX_RK, 15, key store depth; must be at least 15 (AES-256 uses Nr+1 = 15 keys)
PTR_W, 4, key store pointer width; must satisfy 2^PTR_W >= MAX_RK

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
mode_i  in  2  key length: 00=128 (Nr=10), 01=192 (Nr=12), 10=256 (Nr=14), 11=reserved
key_load_i  in  1  request a new key schedule; sampled with mode_i
sched_start_o  out  1  one-cycle start pulse to the key scheduler
rk_valid_i  in  1  round key from the scheduler is valid
rk_i  in  BLK_W  round key material, in ascending order
key_ready_o  out  1  a complete schedule is stored
blk_valid_i  in  1  input block valid
blk_i  in  BLK_W  input block
blk_ready_o  out  1  controller accepts a block
core_start_o  out  1  one-cycle start pulse to the cipher core
core_blk_o  out  BLK_W  block forwarded to the core
core_rk_o  out  BLK_W  round key for the current round
core_last_o  out  1  current round is the final round
core_valid_i  in  1  the core has finished the block
core_blk_i  in  BLK_W  core result
out_valid_o  out  1  result valid
out_blk_o  out  BLK_W  result
out_ready_i  in  1  downstream accepts the result
err_o  out  1  one-cycle pulse on an illegal request

Behaviour:
- States: NOKEY, KEYLOAD, READY, RUN. Reset leads to NOKEY.
- Reset values: all outputs are 0, wr_ptr=rd_ptr=0, and the output register is empty.
- Reset asserted mid-operation aborts everything immediately. The stored schedule is invalidated, so key_ready_o=0, and any pending result is dropped.
- NOKEY or READY with key_load_i=1 and mode_i!=11:
  - Latch mode_i and set wr_ptr=0.
  - Pulse sched_start_o on the next cycle.
  - Move to KEYLOAD and drop key_ready_o.
- key_load_i with mode_i=11 pulses err_o and leaves the state unchanged.
- key_load_i in KEYLOAD or RUN pulses err_o and is otherwise ignored.
- KEYLOAD:
  - Each rk_valid_i writes rk_i to store[wr_ptr], then wr_ptr increments.
  - After write index Nr completes, the next state is READY and key_ready_o=1.
  - rk_valid_i outside KEYLOAD, or beyond Nr+1 keys, is ignored.
- blk_ready_o = (state==READY) && !out_valid_o && !key_load_i. Key load wins when it coincides with a block offer.
- Accepting a block (blk_valid_i && blk_ready_o) in cycle T:
  - Cycle T+1: core_start_o=1, core_blk_o=blk_i, core_rk_o=store[0], state RUN.
  - Cycle T+1+k: core_rk_o=store[k] for k=1..Nr.
  - core_last_o=1 only when k=Nr.
  - core_rk_o and core_blk_o hold their values after k=Nr.
- RUN with core_valid_i: capture core_blk_i into out_blk_o, set out_valid_o=1, return to READY.
- core_valid_i outside RUN is ignored.
- out_valid_o holds, with out_blk_o stable, until out_ready_i. It clears on the cycle after the handshake. No new block is accepted while it is set.
- A key reload in READY with out_valid_o=1 is allowed. The held result is preserved.

Optional Feature:
AESES_DECRYPT_EN
- Defined:
  - Adds input port dec_i (1 bit), sampled at block acceptance.
  - With dec_i=1, round keys are issued in descending order: store[Nr] first, then down to store[0]. core_last_o is asserted with store[0].
  - Adds output core_dec_o, which carries the latched direction.
- Undefined: no dec_i or core_dec_o ports; encryption order only.

Decomposition:
- Package aeses_pkg:
  - mode encoding localparams
  - function nr_of(mode) returning 10/12/14
  - state enum
  - BLK_W default
- Sub-module aeses_rk_store: MAX_RK x BLK_W register file with a synchronous write port and an asynchronous read port indexed by PTR_W.

Test Plan:
1. Reset, then mode 00, key_load_i, and 11 keys rk=i -> sched_start_o pulses once; key_ready_o rises the cycle after key 10; blk_ready_o=1.
2. Mode 10 schedule, then accept block 0x00112233...; the core returns 0xAA.. -> core_rk_o shows store[0]..store[14] on consecutive cycles, core_last_o coincides with store[14], and out_blk_o=0xAA...
3. out_ready_i=0 for 5 cycles after a result -> out_valid_o and out_blk_o stay stable, blk_ready_o=0; a block is accepted the cycle after out_ready_i=1.
4. key_load_i with mode 11, then key_load_i during RUN -> err_o pulses each time; the schedule and the in-flight block are unaffected.
5. Reset asserted at round 5 of a mode-01 operation -> all outputs are 0 the next cycle, key_ready_o=0, and no out_valid_o appears afterwards.
6. (AESES_DECRYPT_EN) mode 00, dec_i=1 -> core_rk_o presents store[10] down to store[0], and core_last_o is asserted with store[0].

Source files
------------

// File: rtl/aeses_pkg.sv
// aeses_pkg: shared constants and types for the AES engine controller.
// Contents: mode encodings, FSM state type, round-count helper, default width.
package aeses_pkg;

    localparam int AES_BLK_W = 128;

    localparam logic [1:0] MODE_128 = 2'b00;
    localparam logic [1:0] MODE_192 = 2'b01;
    localparam logic [1:0] MODE_256 = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    typedef enum logic [1:0] {
        NOKEY,
        KEYLOAD,
        READY,
        RUN
    } aeses_state_t;

    // Number of rounds Nr for a key-length mode.
    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        logic [3:0] nr;
        case (mode)
            MODE_192: nr = 4'd12;
            MODE_256: nr = 4'd14;
            default:  nr = 4'd10;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aeses_rk_store.sv
// aeses_rk_store: MAX_RK x BLK_W round-key register file.
// Ports: clk, we/wa/wd synchronous write, ra/rd asynchronous read.
module aeses_rk_store
    import aeses_pkg::*;
#(
    parameter int BLK_W  = AES_BLK_W,
    parameter int MAX_RK = 15,
    parameter int PTR_W  = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] wa,
    input  logic [BLK_W-1:0] wd,
    input  logic [PTR_W-1:0] ra,
    output logic [BLK_W-1:0] rd
);

    logic [BLK_W-1:0] mem [MAX_RK];

    always_ff @(posedge clk) begin
        if (we && (int'(wa) < MAX_RK)) begin
            mem[wa] <= wd;
        end
    end

    assign rd = (int'(ra) < MAX_RK) ? mem[ra] : '0;

endmodule

// File: rtl/aeses_ctrl.sv
// aeses_ctrl: AES engine controller; key store, block handshakes, round-key sequencing.
// Ports: clk/rst, mode/key_load/sched_start/rk_* (scheduler), blk_* (input),
//        core_* (cipher core), out_* (result), err_o. AESES_DECRYPT_EN adds dec_i/core_dec_o.
module aeses_ctrl
    import aeses_pkg::*;
#(
    parameter int BLK_W  = AES_BLK_W,
    parameter int MAX_RK = 15,
    parameter int PTR_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_i,
    input  logic             key_load_i,
    output logic             sched_start_o,
    input  logic             rk_valid_i,
    input  logic [BLK_W-1:0] rk_i,
    output logic             key_ready_o,
    input  logic             blk_valid_i,
    input  logic [BLK_W-1:0] blk_i,
    output logic             blk_ready_o,
    output logic             core_start_o,
    output logic [BLK_W-1:0] core_blk_o,
    output logic [BLK_W-1:0] core_rk_o,
    output logic             core_last_o,
    input  logic             core_valid_i,
    input  logic [BLK_W-1:0] core_blk_i,
`ifdef AESES_DECRYPT_EN
    input  logic             dec_i,
    output logic             core_dec_o,
`endif
    output logic             out_valid_o,
    output logic [BLK_W-1:0] out_blk_o,
    input  logic             out_ready_i,
    output logic             err_o
);

    aeses_state_t     state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             sched_q, sched_d;
    logic             err_q, err_d;
    logic             start_q, start_d;
    logic             rk_en_q, rk_en_d;
    logic             done_q, done_d;
    logic             dec_q, dec_d;
    logic             ov_q, ov_d;
    logic [BLK_W-1:0] cblk_q, cblk_d;
    logic [BLK_W-1:0] out_q, out_d;
    logic [BLK_W-1:0] rk_rd;
    logic [PTR_W-1:0] nr;
    logic             rk_we;
    logic             rd_end;
    logic             dec_in;

`ifdef AESES_DECRYPT_EN
    assign dec_in     = dec_i;
    assign core_dec_o = dec_q;
`else
    assign dec_in = 1'b0;
`endif

    assign nr = PTR_W'(nr_of(mode_q));

    // Final key index: Nr going up, 0 going down.
    assign rd_end = dec_q ? (rd_ptr_q == '0) : (rd_ptr_q == nr);

    aeses_rk_store #(
        .BLK_W (BLK_W),
        .MAX_RK(MAX_RK),
        .PTR_W (PTR_W)
    ) u_store (
        .clk(clk),
        .we (rk_we),
        .wa (wr_ptr_q),
        .wd (rk_i),
        .ra (rd_ptr_q),
        .rd (rk_rd)
    );

    assign sched_start_o = sched_q;
    assign err_o         = err_q;
    assign core_start_o  = start_q;
    assign core_blk_o    = cblk_q;
    assign core_rk_o     = rk_en_q ? rk_rd : '0;
    // done_q keeps last from re-asserting while the final key is held.
    assign core_last_o   = (state_q == RUN) && rd_end && !done_q;
    assign key_ready_o   = (state_q == READY) || (state_q == RUN);
    assign blk_ready_o   = (state_q == READY) && !ov_q && !key_load_i;
    assign out_valid_o   = ov_q;
    assign out_blk_o     = out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= NOKEY;
            mode_q   <= MODE_128;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sched_q  <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            rk_en_q  <= 1'b0;
            done_q   <= 1'b0;
            dec_q    <= 1'b0;
            ov_q     <= 1'b0;
            cblk_q   <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sched_q  <= sched_d;
            err_q    <= err_d;
            start_q  <= start_d;
            rk_en_q  <= rk_en_d;
            done_q   <= done_d;
            dec_q    <= dec_d;
            ov_q     <= ov_d;
            cblk_q   <= cblk_d;
            out_q    <= out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        sched_d  = 1'b0;
        err_d    = 1'b0;
        start_d  = 1'b0;
        rk_en_d  = rk_en_q;
        done_d   = done_q;
        dec_d    = dec_q;
        ov_d     = ov_q;
        cblk_d   = cblk_q;
        out_d    = out_q;
        rk_we    = 1'b0;

        if (ov_q && out_ready_i) begin
            ov_d = 1'b0;
        end

        unique case (state_q)
            NOKEY, READY: begin
                if (key_load_i) begin
                    if (mode_i == MODE_RSV) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d   = mode_i;
                        wr_ptr_d = '0;
                        sched_d  = 1'b1;
                        rk_en_d  = 1'b0;
                        state_d  = KEYLOAD;
                    end
                end else if (blk_valid_i && blk_ready_o) begin
                    start_d  = 1'b1;
                    cblk_d   = blk_i;
                    dec_d    = dec_in;
                    rd_ptr_d = dec_in ? nr : '0;
                    rk_en_d  = 1'b1;
                    done_d   = 1'b0;
                    state_d  = RUN;
                end
            end
            KEYLOAD: begin
                err_d = key_load_i;
                if (rk_valid_i) begin
                    rk_we    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (wr_ptr_q == nr) begin
                        state_d = READY;
                    end
                end
            end
            RUN: begin
                err_d = key_load_i;
                if (rd_end) begin
                    done_d = 1'b1;
                end else if (dec_q) begin
                    rd_ptr_d = rd_ptr_q - PTR_W'(1);
                end else begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                if (core_valid_i) begin
                    out_d   = core_blk_i;
                    ov_d    = 1'b1;
                    state_d = READY;
                end
            end
            default: state_d = NOKEY;
        endcase
    end

endmodule
